// File: rtl/demux_memoria_1x2_if.sv
// ---------------------------------------------------------------------------
// demux_memoria_1x2_if
//   Bus bundle for the 1-to-2 buffered demultiplexer.
//   Upstream side:   selector, valid_in, data_in -> ready_out
//   Downstream 0/1:  data_outN, valid_outN <- ready_inN
//   Status:          full0, full1
//   Optional:        count0, count1 (present only when DEMUX_STATS_EN is
//                    defined; accepted-word counters per output)
//   Modports:
//     slave  - the demultiplexer itself
//     master - the environment driving upstream and consuming downstream
// ---------------------------------------------------------------------------
interface demux_memoria_1x2_if #(
  parameter int WIDTH = 2
);

  logic             selector;
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             ready_out;

  logic [WIDTH-1:0] data_out0;
  logic             valid_out0;
  logic             ready_in0;

  logic [WIDTH-1:0] data_out1;
  logic             valid_out1;
  logic             ready_in1;

  logic             full0;
  logic             full1;

`ifdef DEMUX_STATS_EN
  logic [7:0]       count0;
  logic [7:0]       count1;

  modport slave (
    input  selector, valid_in, data_in, ready_in0, ready_in1,
    output ready_out, data_out0, valid_out0, data_out1, valid_out1,
           full0, full1, count0, count1
  );

  modport master (
    output selector, valid_in, data_in, ready_in0, ready_in1,
    input  ready_out, data_out0, valid_out0, data_out1, valid_out1,
           full0, full1, count0, count1
  );
`else
  modport slave (
    input  selector, valid_in, data_in, ready_in0, ready_in1,
    output ready_out, data_out0, valid_out0, data_out1, valid_out1,
           full0, full1
  );

  modport master (
    output selector, valid_in, data_in, ready_in0, ready_in1,
    input  ready_out, data_out0, valid_out0, data_out1, valid_out1,
           full0, full1
  );
`endif

endinterface

// File: rtl/demux_memoria_1x2.sv
// ---------------------------------------------------------------------------
// demux_memoria_1x2
//   1-to-2 demultiplexer with a DEPTH-entry FIFO behind each output. One
//   upstream word per cycle is steered by selector into FIFO 0 or FIFO 1;
//   each FIFO is drained independently by its own valid/ready consumer.
//   Outputs are first-word-fall-through from registered storage, so a word
//   pushed at edge k is visible from cycle k+1 (no same-cycle bypass).
//
// Ports
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high; clears pointers, occupancy, counters
//   bus    - demux_memoria_1x2_if.slave (upstream, two downstream ports,
//            full flags and optional counters)
//
// Parameters
//   WIDTH  - data word width in bits
//   DEPTH  - entries per FIFO; power of two, >= 2
//
// Configuration
//   DEMUX_STATS_EN - when defined, count0/count1 count accepted pushes per
//                    output, saturating at 8'hFF. When undefined, the
//                    counters and their ports are absent.
// ---------------------------------------------------------------------------
module demux_memoria_1x2 #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  demux_memoria_1x2_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [WIDTH-1:0] mem_r    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_r [2];
  logic [PW-1:0]    rd_ptr_r [2];
  logic [OW-1:0]    occ_r    [2];

  logic [1:0] valid_s;
  logic [1:0] full_s;
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic [1:0] ready_in_s;
  logic       ready_s;

  // Status flags and handshakes, derived only from registered occupancy
  always_comb begin
    valid_s    = 2'b00;
    full_s     = 2'b00;
    push_s     = 2'b00;
    pop_s      = 2'b00;
    ready_s    = 1'b0;
    ready_in_s = {bus.ready_in1, bus.ready_in0};

    for (int i = 0; i < 2; i++) begin
      valid_s[i] = (occ_r[i] != {OW{1'b0}});
      full_s[i]  = (occ_r[i] == DEPTH_C);
    end

    // Readiness follows only the selected FIFO, so a full output never
    // stalls traffic steered to the other one. A pop on a full FIFO does
    // not open a slot for the same cycle.
    if (bus.selector) begin
      ready_s = !full_s[1];
    end else begin
      ready_s = !full_s[0];
    end

    push_s[0] = bus.valid_in && ready_s && !bus.selector;
    push_s[1] = bus.valid_in && ready_s &&  bus.selector;

    // ready_inN on an empty FIFO is ignored
    pop_s = valid_s & ready_in_s;
  end

  // FIFO storage, pointers and occupancy for both outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_r[i] <= {PW{1'b0}};
        rd_ptr_r[i] <= {PW{1'b0}};
        occ_r[i]    <= {OW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) begin
          mem_r[i][wr_ptr_r[i]] <= bus.data_in;
          wr_ptr_r[i]           <= wr_ptr_r[i] + PW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   occ_r[i] <= occ_r[i] + OW'(1);
          2'b01:   occ_r[i] <= occ_r[i] - OW'(1);
          default: occ_r[i] <= occ_r[i];
        endcase
      end
    end
  end

  assign bus.ready_out  = ready_s;
  assign bus.valid_out0 = valid_s[0];
  assign bus.valid_out1 = valid_s[1];
  assign bus.full0      = full_s[0];
  assign bus.full1      = full_s[1];

  // Head is masked to zero while empty so stale storage never leaks out
  assign bus.data_out0 = valid_s[0] ? mem_r[0][rd_ptr_r[0]] : {WIDTH{1'b0}};
  assign bus.data_out1 = valid_s[1] ? mem_r[1][rd_ptr_r[1]] : {WIDTH{1'b0}};

`ifdef DEMUX_STATS_EN
  logic [7:0] count_r [2];

  // Saturating per-output accepted-word counters
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r[0] <= 8'h00;
      count_r[1] <= 8'h00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i] && (count_r[i] != 8'hFF)) begin
          count_r[i] <= count_r[i] + 8'h01;
        end
      end
    end
  end

  assign bus.count0 = count_r[0];
  assign bus.count1 = count_r[1];
`endif

endmodule

// File: tb/tb_demux_memoria_1x2.sv
// ---------------------------------------------------------------------------
// tb_demux_memoria_1x2
//   Directed bench for demux_memoria_1x2 (WIDTH=2, DEPTH=4). Inputs are
//   driven 1 time unit after each rising edge and outputs are sampled
//   1 unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_demux_memoria_1x2;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  demux_memoria_1x2_if #(.WIDTH(2)) bus ();

  demux_memoria_1x2 #(.WIDTH(2), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and step just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset          = 1'b1;
    bus.selector   = 1'b0;
    bus.valid_in   = 1'b1;
    bus.data_in    = 2'b11;
    bus.ready_in0  = 1'b0;
    bus.ready_in1  = 1'b0;

    // 1. Reset held two cycles with valid_in high
    tick();
    tick();
    settle();
    check_eq("rst_ready_out", 32'(bus.ready_out), 32'd1);
    check_eq("rst_valid0",    32'(bus.valid_out0), 32'd0);
    check_eq("rst_valid1",    32'(bus.valid_out1), 32'd0);
    check_eq("rst_data0",     32'(bus.data_out0), 32'd0);
    check_eq("rst_data1",     32'(bus.data_out1), 32'd0);
    check_eq("rst_full0",     32'(bus.full0), 32'd0);
`ifdef DEMUX_STATS_EN
    check_eq("rst_count0",    32'(bus.count0), 32'd0);
`endif
    reset        = 1'b0;
    bus.valid_in = 1'b0;

    // 2. Two words to output 0, consumer 0 always ready
    bus.selector  = 1'b0;
    bus.valid_in  = 1'b1;
    bus.data_in   = 2'b01;
    bus.ready_in0 = 1'b1;
    tick();
    settle();
    check_eq("t2_valid0_k1", 32'(bus.valid_out0), 32'd1);
    check_eq("t2_data0_k1",  32'(bus.data_out0), 32'h1);
    bus.data_in = 2'b10;
    tick();
    bus.valid_in = 1'b0;
    settle();
    check_eq("t2_data0_k2",  32'(bus.data_out0), 32'h2);
    check_eq("t2_valid1",    32'(bus.valid_out1), 32'd0);
    tick();
    settle();
    check_eq("t2_empty0",    32'(bus.valid_out0), 32'd0);
    check_eq("t2_zero0",     32'(bus.data_out0), 32'd0);
    bus.ready_in0 = 1'b0;

    // 3. Fill FIFO 1, then steer to FIFO 0 past the backpressure
    bus.selector = 1'b1;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 2'(i);
      tick();
    end
    settle();
    check_eq("t3_full1",      32'(bus.full1), 32'd1);
    check_eq("t3_ready_sel1", 32'(bus.ready_out), 32'd0);
    check_eq("t3_head1",      32'(bus.data_out1), 32'h0);
    bus.selector = 1'b0;
    bus.data_in  = 2'b11;
    settle();
    check_eq("t3_ready_sel0", 32'(bus.ready_out), 32'd1);
    tick();
    bus.valid_in = 1'b0;
    settle();
    check_eq("t3_valid0",     32'(bus.valid_out0), 32'd1);
    check_eq("t3_data0",      32'(bus.data_out0), 32'h3);
    check_eq("t3_full1_hold", 32'(bus.full1), 32'd1);
    bus.ready_in0 = 1'b1;
    tick();
    bus.ready_in0 = 1'b0;
    settle();
    check_eq("t3_drain0",     32'(bus.valid_out0), 32'd0);

    // 4. Full FIFO 1: pop and push together -> push refused, then accepted
    bus.selector  = 1'b1;
    bus.valid_in  = 1'b1;
    bus.data_in   = 2'b10;
    bus.ready_in1 = 1'b1;
    settle();
    check_eq("t4_refuse", 32'(bus.ready_out), 32'd0);
    tick();
    bus.ready_in1 = 1'b0;
    settle();
    check_eq("t4_notfull",  32'(bus.full1), 32'd0);
    check_eq("t4_ready",    32'(bus.ready_out), 32'd1);
    tick();
    bus.valid_in = 1'b0;
    settle();
    check_eq("t4_full_again", 32'(bus.full1), 32'd1);
    bus.ready_in1 = 1'b1;
    check_eq("t4_order0", 32'(bus.data_out1), 32'h1);
    tick();
    check_eq("t4_order1", 32'(bus.data_out1), 32'h2);
    tick();
    check_eq("t4_order2", 32'(bus.data_out1), 32'h3);
    tick();
    check_eq("t4_order3", 32'(bus.data_out1), 32'h2);
    tick();
    check_eq("t4_empty1", 32'(bus.valid_out1), 32'd0);

    // ready_in1 on an empty FIFO is ignored
    tick();
    check_eq("t4_idle_valid1", 32'(bus.valid_out1), 32'd0);
    check_eq("t4_idle_full1",  32'(bus.full1), 32'd0);

    // Push into an empty FIFO while its consumer is ready: no bypass
    bus.valid_in = 1'b1;
    bus.data_in  = 2'b11;
    tick();
    bus.valid_in = 1'b0;
    settle();
    check_eq("t4_nobypass_v", 32'(bus.valid_out1), 32'd1);
    check_eq("t4_nobypass_d", 32'(bus.data_out1), 32'h3);
    tick();
    check_eq("t4_popped", 32'(bus.valid_out1), 32'd0);
    bus.ready_in1 = 1'b0;

    // 5. Reset with three words in FIFO 0
    bus.selector = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = 2'b01;
    tick();
    bus.data_in  = 2'b10;
    tick();
    bus.data_in  = 2'b11;
    tick();
    settle();
    check_eq("t5_pre_valid0", 32'(bus.valid_out0), 32'd1);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    settle();
    check_eq("t5_valid0", 32'(bus.valid_out0), 32'd0);
    check_eq("t5_data0",  32'(bus.data_out0), 32'd0);
    check_eq("t5_full0",  32'(bus.full0), 32'd0);
`ifdef DEMUX_STATS_EN
    check_eq("t5_count0", 32'(bus.count0), 32'd0);
`endif
    bus.valid_in = 1'b1;
    bus.data_in  = 2'b10;
    tick();
    bus.valid_in = 1'b0;
    settle();
    check_eq("t5_fresh_d", 32'(bus.data_out0), 32'h2);
    bus.ready_in0 = 1'b1;
    tick();
    check_eq("t5_no_stale", 32'(bus.valid_out0), 32'd0);
    bus.ready_in0 = 1'b0;

`ifdef DEMUX_STATS_EN
    // 6. 300 pushes to output 0 saturate its counter (one push already made)
    bus.selector  = 1'b0;
    bus.valid_in  = 1'b1;
    bus.ready_in0 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.data_in = 2'(i);
      tick();
    end
    bus.valid_in = 1'b0;
    settle();
    check_eq("t6_count0", 32'(bus.count0), 32'hFF);
    check_eq("t6_count1", 32'(bus.count1), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
